// File: rtl/piso_bit_feeder_if.sv
// piso_bit_feeder_if -- bundle of parallel-in / serial-out feeder signals.
//   din, len, din_valid, flush : word offer and discard control (master -> slave)
//   din_ready                  : feeder can take a word this cycle (slave -> master)
//   sout, sout_valid, last     : serial bit stream with end-of-word marker
//   busy                       : holding register or shifter occupied
// The feeder itself uses the slave modport; the producer/consumer side uses master.
interface piso_bit_feeder_if #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0] din;
  logic [LW-1:0]    len;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport slave (
    input  din, len, din_valid, flush,
    output din_ready, sout, sout_valid, last, busy
  );

  modport master (
    output din, len, din_valid, flush,
    input  din_ready, sout, sout_valid, last, busy
  );
endinterface

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder -- serializes words of 1..WIDTH bits, MSB of the effective
// length first, through one holding register and one shift register.
//   clk  : single clock, all state changes on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : piso_bit_feeder_if slave modport (word input, serial output, status)
// A word accepted at edge k is loaded into the shifter at edge k+1 when the
// shifter is idle, or at the edge of the current word's last bit, so words
// stream back-to-back without gaps. din_ready depends on registered state only.
module piso_bit_feeder #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_bit_feeder_if.slave      bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);

  // Holding register
  logic             hold_full;
  logic [WIDTH-1:0] hold_word;
  logic [LW-1:0]    hold_len;

  // Shifter: word is kept left-aligned so the current bit is always the MSB
  logic [0:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [LW-1:0]    cnt;        // bits remaining, including the one on sout

  logic [LW-1:0]    eff_len;
  logic             accept;
  logic             last_bit;
  logic             load;

  // 0 or anything above WIDTH selects the full word.
  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eff_len = bus.len;
    if (bus.len == '0 || bus.len > FULL_LEN) eff_len = FULL_LEN;
  end

  // Flush wins over a simultaneous offer.
  assign accept   = bus.din_valid & ~hold_full & ~bus.flush;
  assign last_bit = (state == SHIFT) && (cnt == LW'(1));
  assign load     = hold_full && ((state == IDLE) || last_bit);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else if (bus.flush) begin
      hold_full <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      // accept and load are mutually exclusive: one needs hold empty, the other full
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;

      if (load) begin
        state <= SHIFT;
        cnt   <= hold_len;
      end else if (state == SHIFT) begin
        if (last_bit) state <= IDLE;
        cnt <= cnt - LW'(1);
      end
    end
  end

  // NOTE: datapath registers carry no reset; every output is qualified by reset control state.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_word <= bus.din;
      hold_len  <= eff_len;
    end
    if (load)
      shift_reg <= hold_word << (FULL_LEN - hold_len);
    else if (state == SHIFT)
      shift_reg <= shift_reg << 1;
  end

  assign bus.din_ready  = ~hold_full;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) & shift_reg[WIDTH-1];
  assign bus.last       = last_bit;
  assign bus.busy       = hold_full | (state == SHIFT);

endmodule
